// File: rtl/cn_upd_pkg.sv
// Shared constants, FSM state type and base-address helper for the CN LUT refresh controller.
// Optional feature macro used by the top: CN_UPD_ERR_FLAG_EN (adds the sticky upd_err output).
package cn_upd_pkg;

   localparam int ROM_ADDR_BW    = 10;
   localparam int PAGE_ADDR_BW   = 5;
   localparam int ITER_ADDR_BW   = 6;
   localparam int CN_LOAD_CYCLE  = 32;
   localparam int ITER_ROM_GROUP = 25;
   localparam int MAX_ITER       = 50;
   localparam int ROM_LATENCY    = 2;

   localparam int HALF_LOAD = CN_LOAD_CYCLE / 2;
   localparam int TMR_BW    = $clog2(ROM_LATENCY) + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      PRIME = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } upd_state_e;

   // Port-A base address of an iteration, relative to its ROM group, truncated to the ROM bus.
   function automatic logic [ROM_ADDR_BW-1:0] group_base(input logic [ITER_ADDR_BW-1:0] iter);
      int g;
      g = (int'(iter) >= ITER_ROM_GROUP) ? int'(iter) - ITER_ROM_GROUP : int'(iter);
      return ROM_ADDR_BW'(g * CN_LOAD_CYCLE);
   endfunction

endpackage

// File: rtl/cn_upd_page_gen.sv
// Dual-port page counter for the LUT RAM write burst: LEN write cycles after a start pulse,
// port B trailing port A by LEN pages.
module cn_upd_page_gen
   import cn_upd_pkg::*;
#(
   parameter int PAGE_BW = PAGE_ADDR_BW,
   parameter int LEN     = HALF_LOAD
) (
   input  logic               clk_sys,
   input  logic               rst_b,
   input  logic               i_start,
   output logic               o_wr_en,
   output logic [PAGE_BW-1:0] o_page_a,
   output logic [PAGE_BW-1:0] o_page_b,
   output logic               o_last
);

   localparam logic [PAGE_BW-1:0] LEN_P  = PAGE_BW'(LEN);
   localparam logic [PAGE_BW-1:0] LAST_P = PAGE_BW'(LEN - 1);

   logic               r_wr_en;
   logic [PAGE_BW-1:0] r_page_a;
   logic [PAGE_BW-1:0] r_page_b;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         r_wr_en  <= 1'b0;
         r_page_a <= '0;
         r_page_b <= LEN_P;
      end else if (r_wr_en) begin
         if (r_page_a == LAST_P) begin
            r_wr_en  <= 1'b0;
            r_page_a <= '0;
            r_page_b <= LEN_P;
         end else begin
            r_page_a <= r_page_a + PAGE_BW'(1);
            r_page_b <= r_page_b + PAGE_BW'(1);
         end
      end else if (i_start) begin
         r_wr_en  <= 1'b1;
         r_page_a <= '0;
         r_page_b <= LEN_P;
      end
   end

   assign o_wr_en  = r_wr_en;
   assign o_page_a = r_page_a;
   assign o_page_b = r_page_b;
   assign o_last   = r_wr_en && (r_page_a == LAST_P);

endmodule

// File: rtl/cn_iter_update_ctrl.sv
// Check-node IB-LUT refresh controller: per-iteration ROM base addresses, fetch strobe and page-write sequencing.
// Optional: define CN_UPD_ERR_FLAG_EN to add the sticky upd_err flag for dropped requests.
//
// state | meaning
// IDLE  | waiting for iter_update_req (ignored once iter_cnt == MAX_ITER)
// FETCH | rom_port_fetch low for one cycle; base addresses already registered
// PRIME | ROM_LATENCY cycles while the latched ROM words settle
// WRITE | HALF_LOAD page writes on both RAM ports
// DONE  | upd_done pulse; iter_cnt advances on exit
module cn_iter_update_ctrl
   import cn_upd_pkg::*;
(
   input  logic                    write_clk,
   input  logic                    rstn,
   input  logic                    iter_update_req,
   output logic                    rom_port_fetch,
   output logic [ROM_ADDR_BW-1:0]  latch_iterA,
   output logic [ROM_ADDR_BW-1:0]  latch_iterB,
   output logic                    iter_switch,
   output logic                    wr_en,
   output logic [PAGE_ADDR_BW-1:0] wr_page_addrA,
   output logic [PAGE_ADDR_BW-1:0] wr_page_addrB,
   output logic [ITER_ADDR_BW-1:0] iter_cnt,
   output logic                    upd_busy,
   output logic                    upd_done,
   output logic                    max_iter_reached
`ifdef CN_UPD_ERR_FLAG_EN
   ,
   output logic                    upd_err
`endif
);

   localparam logic [ITER_ADDR_BW-1:0] ITER_MAX_P   = ITER_ADDR_BW'(MAX_ITER);
   localparam logic [ITER_ADDR_BW-1:0] ITER_GROUP_P = ITER_ADDR_BW'(ITER_ROM_GROUP);
   localparam logic [ROM_ADDR_BW-1:0]  HALF_ROM_P   = ROM_ADDR_BW'(HALF_LOAD);
   localparam logic [TMR_BW-1:0]       PRIME_LAST_P = TMR_BW'(ROM_LATENCY - 1);

   upd_state_e              r_state;
   logic [TMR_BW-1:0]       r_tmr;
   logic                    r_fetch_n;
   logic [ROM_ADDR_BW-1:0]  r_iter_a;
   logic [ROM_ADDR_BW-1:0]  r_iter_b;
   logic                    r_switch;
   logic [ITER_ADDR_BW-1:0] r_iter_cnt;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_max;

   logic                    w_page_start;
   logic                    w_page_last;
   logic [ROM_ADDR_BW-1:0]  w_base;

   assign w_base       = group_base(r_iter_cnt);
   assign w_page_start = (r_state == PRIME) && (r_tmr == '0);

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_tmr      <= '0;
         r_fetch_n  <= 1'b1;
         r_iter_a   <= '0;
         r_iter_b   <= HALF_ROM_P;
         r_switch   <= 1'b0;
         r_iter_cnt <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_max      <= 1'b0;
      end else begin
         r_fetch_n <= 1'b1;
         r_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (iter_update_req && (r_iter_cnt < ITER_MAX_P)) begin
                  r_state   <= FETCH;
                  r_fetch_n <= 1'b0;
                  r_busy    <= 1'b1;
                  // Addresses land with the strobe so the latch counters seed from stable values.
                  r_iter_a  <= w_base;
                  r_iter_b  <= w_base + HALF_ROM_P;
                  r_switch  <= (r_iter_cnt >= ITER_GROUP_P);
               end
            end
            FETCH: begin
               r_state <= PRIME;
               r_tmr   <= PRIME_LAST_P;
            end
            PRIME: begin
               if (r_tmr == '0) begin
                  r_state <= WRITE;
               end else begin
                  r_tmr <= r_tmr - TMR_BW'(1);
               end
            end
            WRITE: begin
               if (w_page_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               if (r_iter_cnt < ITER_MAX_P) begin
                  r_iter_cnt <= r_iter_cnt + ITER_ADDR_BW'(1);
                  r_max      <= ((r_iter_cnt + ITER_ADDR_BW'(1)) == ITER_MAX_P);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   cn_upd_page_gen #(
      .PAGE_BW (PAGE_ADDR_BW),
      .LEN     (HALF_LOAD)
   ) u_page_gen (
      .clk_sys  (write_clk),
      .rst_b    (rstn),
      .i_start  (w_page_start),
      .o_wr_en  (wr_en),
      .o_page_a (wr_page_addrA),
      .o_page_b (wr_page_addrB),
      .o_last   (w_page_last)
   );

`ifdef CN_UPD_ERR_FLAG_EN
   logic r_err;

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_err <= 1'b0;
      end else if (iter_update_req && (r_busy || r_max)) begin
         r_err <= 1'b1;
      end
   end

   assign upd_err = r_err;
`endif

   assign rom_port_fetch   = r_fetch_n;
   assign latch_iterA      = r_iter_a;
   assign latch_iterB      = r_iter_b;
   assign iter_switch      = r_switch;
   assign iter_cnt         = r_iter_cnt;
   assign upd_busy         = r_busy;
   assign upd_done         = r_done;
   assign max_iter_reached = r_max;

endmodule
